// File: rtl/rxe_pktctl_pkg.sv
// Shared enet receive definitions: controller state encoding and statistics counter width.
package rxe_pktctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2,
    ST_FULL  = 2'd3
  } pkt_state_t;

  localparam int CNT_W = 16;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX  = {CNT_W{1'b1}};
  localparam cnt_t CNT_ZERO = {CNT_W{1'b0}};

endpackage

// File: rtl/rxe_pktctl_if.sv
// Receive-controller signal bundle: byte stream and CPU controls in, buffer writes and status out.
interface rxe_pktctl_if #(
  parameter int AW = 11
) ();
  import rxe_pktctl_pkg::*;

  logic          i_ce;
  logic          i_en;
  logic          i_v;
  logic [7:0]    i_byte;
  logic          i_err;
  logic          i_clear;
  logic          i_cnt_clr;
  logic          o_wr;
  logic [AW-1:0] o_waddr;
  logic [7:0]    o_wdata;
  logic          o_pkt_ready;
  logic [AW:0]   o_len;
  logic          o_busy;
  cnt_t          o_drop_cnt;
  cnt_t          o_miss_cnt;

  modport master (
    output i_ce, i_en, i_v, i_byte, i_err, i_clear, i_cnt_clr,
    input  o_wr, o_waddr, o_wdata, o_pkt_ready, o_len, o_busy, o_drop_cnt, o_miss_cnt
  );

  modport slave (
    input  i_ce, i_en, i_v, i_byte, i_err, i_clear, i_cnt_clr,
    output o_wr, o_waddr, o_wdata, o_pkt_ready, o_len, o_busy, o_drop_cnt, o_miss_cnt
  );

endinterface

// File: rtl/rxe_pktctl_satcount16.sv
// Saturating statistics counter; clear beats load, load beats increment, holds at all-ones.
module satcount16
  import rxe_pktctl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic ld,
  input  cnt_t ld_val,
  input  logic inc,
  output cnt_t cnt
);

  cnt_t cnt_q;
  cnt_t cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CNT_ZERO;
    end else if (ld) begin
      cnt_d = ld_val;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rxe_pktctl.sv
// Ethernet receive packet controller: writes one frame into a single-packet buffer, holds it
// for the CPU, and counts dropped and missed frames. Buffer writes lag the byte by one clock.
module rxe_pktctl
  import rxe_pktctl_pkg::*;
#(
  parameter int AW       = 11,
  parameter int MAXBYTES = 1518
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic          i_en,
  input  logic          i_v,
  input  logic [7:0]    i_byte,
  input  logic          i_err,
  input  logic          i_clear,
  input  logic          i_cnt_clr,
  output logic          o_wr,
  output logic [AW-1:0] o_waddr,
  output logic [7:0]    o_wdata,
  output logic          o_pkt_ready,
  output logic [AW:0]   o_len,
  output logic          o_busy,
  output cnt_t          o_drop_cnt,
  output cnt_t          o_miss_cnt
);

  pkt_state_t    state_q, state_d;
  logic          last_v_q, last_v_d;
  logic [AW:0]   len_q, len_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          rdy_q, rdy_d;
  logic [AW:0]   olen_q, olen_d;
  logic          drop_inc;
  logic          miss_inc;
  logic          start;

  assign start = i_ce && i_v && !last_v_q;

  always_comb begin
    state_d  = state_q;
    last_v_d = i_ce ? i_v : last_v_q;
    len_d    = len_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    wr_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    rdy_d    = rdy_q;
    olen_d   = olen_q;
    drop_inc = 1'b0;
    miss_inc = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (i_en) begin
            state_d = ST_RECV;
            wr_d    = 1'b1;
            waddr_d = '0;
            wdata_d = i_byte;
            len_d   = (AW+1)'(1);
            err_d   = 1'b0;
            ovf_d   = 1'b0;
          end else begin
            miss_inc = 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (!i_en) begin
          state_d = ST_IDLE;
        end else if (i_ce) begin
          if (i_err) err_d = 1'b1;
          if (i_v) begin
            // len_q[AW] set means the buffer already holds 2^AW bytes
            if (!len_q[AW]) begin
              wr_d    = 1'b1;
              waddr_d = len_q[AW-1:0];
              wdata_d = i_byte;
              len_d   = len_q + (AW+1)'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (!i_en) begin
          state_d = ST_IDLE;
        end else if (i_ce) begin
          if (err_q || i_err || ovf_q || (32'(len_q) > MAXBYTES)) begin
            drop_inc = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_FULL;
            olen_d  = len_q;
            rdy_d   = 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (start) miss_inc = 1'b1;
        if (i_clear) begin
          state_d = ST_IDLE;
          rdy_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      last_v_q <= 1'b0;
      len_q    <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wr_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      rdy_q    <= 1'b0;
      olen_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_v_q <= last_v_d;
      len_q    <= len_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      wr_q     <= wr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      rdy_q    <= rdy_d;
      olen_q   <= olen_d;
    end
  end

  satcount16 u_drop_cnt (
    .clk    (i_clk),
    .rst    (i_reset),
    .clr    (i_cnt_clr),
    .ld     (1'b0),
    .ld_val (CNT_ZERO),
    .inc    (drop_inc),
    .cnt    (o_drop_cnt)
  );

  satcount16 u_miss_cnt (
    .clk    (i_clk),
    .rst    (i_reset),
    .clr    (i_cnt_clr),
    .ld     (1'b0),
    .ld_val (CNT_ZERO),
    .inc    (miss_inc),
    .cnt    (o_miss_cnt)
  );

  assign o_wr        = wr_q;
  assign o_waddr     = waddr_q;
  assign o_wdata     = wdata_q;
  assign o_pkt_ready = rdy_q;
  assign o_len       = olen_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rxe_pktctl.sv
// Bench for rxe_pktctl (AW=6): directed frames, write/length scoreboard, counter checks.
module tb_rxe_pktctl;
  import rxe_pktctl_pkg::*;

  localparam int AW = 6;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  always #5 i_clk = ~i_clk;

  rxe_pktctl_if #(.AW(AW)) bus ();

  rxe_pktctl #(.AW(AW), .MAXBYTES(1518)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_ce        (bus.i_ce),
    .i_en        (bus.i_en),
    .i_v         (bus.i_v),
    .i_byte      (bus.i_byte),
    .i_err       (bus.i_err),
    .i_clear     (bus.i_clear),
    .i_cnt_clr   (bus.i_cnt_clr),
    .o_wr        (bus.o_wr),
    .o_waddr     (bus.o_waddr),
    .o_wdata     (bus.o_wdata),
    .o_pkt_ready (bus.o_pkt_ready),
    .o_len       (bus.o_len),
    .o_busy      (bus.o_busy),
    .o_drop_cnt  (bus.o_drop_cnt),
    .o_miss_cnt  (bus.o_miss_cnt)
  );

  logic sc_clr = 1'b0, sc_ld = 1'b0, sc_inc = 1'b0;
  cnt_t sc_val = CNT_ZERO;
  cnt_t sc_cnt;

  satcount16 u_sc (
    .clk    (i_clk),
    .rst    (i_reset),
    .clr    (sc_clr),
    .ld     (sc_ld),
    .ld_val (sc_val),
    .inc    (sc_inc),
    .cnt    (sc_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [13:0] wq[$];     // {addr[5:0], data[7:0]}
  int          lq[$];
  logic        rdy_prev = 1'b0;
  logic        en_r = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: every buffer write and every new held packet is popped and compared.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (bus.o_wr === 1'b1) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wr addr=%0d data=%0h", bus.o_waddr, bus.o_wdata);
        end else begin
          logic [13:0] e;
          e = wq.pop_front();
          if ({bus.o_waddr, bus.o_wdata} !== e) begin
            errors++;
            $display("FAIL wr addr=%0d data=%0h exp addr=%0d data=%0h",
                     bus.o_waddr, bus.o_wdata, e[13:8], e[7:0]);
          end
        end
      end
      if (bus.o_pkt_ready === 1'b1 && !rdy_prev) begin
        checks++;
        if (lq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready len=%0d", bus.o_len);
        end else begin
          int el;
          el = lq.pop_front();
          if (32'(bus.o_len) !== el) begin
            errors++;
            $display("FAIL pkt_len got=%0d exp=%0d", bus.o_len, el);
          end
        end
      end
    end
    rdy_prev = bus.o_pkt_ready;
  end

  task automatic tick(input logic ce, input logic v, input logic [7:0] b,
                      input logic err, input logic cc);
    @(negedge i_clk);
    bus.i_ce = ce; bus.i_v = v; bus.i_byte = b;
    bus.i_err = err; bus.i_cnt_clr = cc; bus.i_en = en_r;
  endtask

  task automatic send_pkt(input int n, input logic [7:0] seed, input int nwr, input bit gaps);
    for (int i = 0; i < n; i++) begin
      logic [7:0] d;
      d = seed + 8'(i);
      if (i < nwr) wq.push_back({6'(i), d});
      tick(1'b1, 1'b1, d, 1'b0, 1'b0);
      if (gaps) tick(1'b0, 1'b0, 8'hEE, 1'b0, 1'b0);
    end
  endtask

  task automatic finish_pkt(input logic err, input logic cc);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 8'h00, err, cc);
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    @(negedge i_clk); bus.i_clear = 1'b1;
    @(negedge i_clk); bus.i_clear = 1'b0;
  endtask

  initial begin
    bus.i_ce = 0; bus.i_en = 1; bus.i_v = 0; bus.i_byte = 0;
    bus.i_err = 0; bus.i_clear = 0; bus.i_cnt_clr = 0;
    repeat (3) @(negedge i_clk);
    chk("rst_wr", 32'(bus.o_wr), 0);
    chk("rst_rdy", 32'(bus.o_pkt_ready), 0);
    chk("rst_len", 32'(bus.o_len), 0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_drop", 32'(bus.o_drop_cnt), 0);
    i_reset = 1'b0;

    // 64-byte frame with idle byte-times between bytes
    send_pkt(64, 8'h10, 64, 1'b1);
    lq.push_back(64);
    finish_pkt(1'b0, 1'b0);
    chk("p1_rdy", 32'(bus.o_pkt_ready), 1);
    chk("p1_len", 32'(bus.o_len), 64);
    chk("p1_busy", 32'(bus.o_busy), 1);

    // frame arriving while the buffer is held
    send_pkt(10, 8'h80, 0, 1'b0);
    finish_pkt(1'b0, 1'b0);
    chk("full_miss", 32'(bus.o_miss_cnt), 1);
    chk("full_rdy", 32'(bus.o_pkt_ready), 1);
    do_clear();
    chk("clr_rdy", 32'(bus.o_pkt_ready), 0);
    chk("clr_busy", 32'(bus.o_busy), 0);

    send_pkt(20, 8'hC0, 20, 1'b0);
    lq.push_back(20);
    finish_pkt(1'b0, 1'b0);
    chk("p3_len", 32'(bus.o_len), 20);
    do_clear();

    // error reported during CHECK
    send_pkt(40, 8'h33, 40, 1'b0);
    finish_pkt(1'b1, 1'b0);
    chk("err_drop", 32'(bus.o_drop_cnt), 1);
    chk("err_rdy", 32'(bus.o_pkt_ready), 0);
    chk("err_busy", 32'(bus.o_busy), 0);

    // overflow: only 2^AW bytes written
    send_pkt(70, 8'h01, 64, 1'b0);
    finish_pkt(1'b0, 1'b0);
    chk("ovf_drop", 32'(bus.o_drop_cnt), 2);
    chk("ovf_rdy", 32'(bus.o_pkt_ready), 0);

    // reset in the middle of a frame; remaining bytes flow while reset is held
    send_pkt(10, 8'h55, 10, 1'b0);
    @(negedge i_clk);
    #2 i_reset = 1'b1;
    #1;
    chk("mrst_wr", 32'(bus.o_wr), 0);
    chk("mrst_waddr", 32'(bus.o_waddr), 0);
    chk("mrst_wdata", 32'(bus.o_wdata), 0);
    chk("mrst_busy", 32'(bus.o_busy), 0);
    chk("mrst_drop", 32'(bus.o_drop_cnt), 0);
    for (int i = 10; i < 15; i++) tick(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge i_clk); i_reset = 1'b0;
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("mrst_after_busy", 32'(bus.o_busy), 0);

    // receive enable dropped mid-frame
    send_pkt(8, 8'h20, 8, 1'b0);
    en_r = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
    finish_pkt(1'b0, 1'b0);
    en_r = 1'b1;
    chk("abort_busy", 32'(bus.o_busy), 0);
    chk("abort_drop", 32'(bus.o_drop_cnt), 0);
    chk("abort_miss", 32'(bus.o_miss_cnt), 0);
    chk("abort_rdy", 32'(bus.o_pkt_ready), 0);

    // frame while disabled
    en_r = 1'b0;
    send_pkt(5, 8'h44, 0, 1'b0);
    finish_pkt(1'b0, 1'b0);
    en_r = 1'b1;
    chk("dis_miss", 32'(bus.o_miss_cnt), 1);

    // drop, then drop coinciding with counter clear
    send_pkt(5, 8'h60, 5, 1'b0);
    finish_pkt(1'b1, 1'b0);
    chk("drop1", 32'(bus.o_drop_cnt), 1);
    send_pkt(5, 8'h70, 5, 1'b0);
    finish_pkt(1'b1, 1'b1);
    chk("drop_clr", 32'(bus.o_drop_cnt), 0);
    chk("miss_clr", 32'(bus.o_miss_cnt), 0);

    // saturation on a preset counter
    @(negedge i_clk); sc_ld = 1'b1; sc_val = 16'hFFFF;
    @(negedge i_clk); sc_ld = 1'b0; sc_inc = 1'b1;
    @(negedge i_clk);
    chk("sat_hold", 32'(sc_cnt), 32'hFFFF);
    sc_clr = 1'b1;
    @(negedge i_clk); sc_clr = 1'b0;
    chk("sat_clr_inc", 32'(sc_cnt), 0);
    @(negedge i_clk); sc_inc = 1'b0;
    chk("sat_inc", 32'(sc_cnt), 1);

    repeat (3) @(negedge i_clk);
    chk("wq_empty", 32'(wq.size()), 0);
    chk("lq_empty", 32'(lq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rxe_pktctl.md
RXE_PKTCTL -- requirements
Module: rxe_pktctl

Interface
REQ-001 SHALL have parameter AW, default 11, meaning byte-address width of the packet buffer (2^AW bytes).
REQ-002 SHALL have parameter MAXBYTES, default 1518, meaning the largest accepted frame length in bytes, CRC included.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; reset is asynchronous and active-high.
REQ-004 SHALL have port i_reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port i_ce, input, 1 bit: byte-time strobe; all datapath inputs are qualified by it.
REQ-006 SHALL have port i_en, input, 1 bit: receive enable.
REQ-007 SHALL have port i_v, input, 1 bit: byte valid (packet present).
REQ-008 SHALL have port i_byte, input, 8 bits: received byte.
REQ-009 SHALL have port i_err, input, 1 bit: OR of the upstream checker errors (minimum length, CRC, address).
REQ-010 SHALL have port i_clear, input, 1 bit: CPU release of the held packet.
REQ-011 SHALL have port i_cnt_clr, input, 1 bit: zero both statistics counters.
REQ-012 SHALL have port o_wr, output, 1 bit: buffer write strobe.
REQ-013 SHALL have port o_waddr, output, AW bits: buffer write address.
REQ-014 SHALL have port o_wdata, output, 8 bits: buffer write data.
REQ-015 SHALL have port o_pkt_ready, output, 1 bit: a packet is held and valid.
REQ-016 SHALL have port o_len, output, AW+1 bits: held packet length in bytes.
REQ-017 SHALL have port o_busy, output, 1 bit: state is not IDLE.
REQ-018 SHALL have port o_drop_cnt, output, 16 bits: count of rejected packets.
REQ-019 SHALL have port o_miss_cnt, output, 16 bits: count of packets ignored because the block was disabled or full.

Function
REQ-020 SHALL implement states IDLE, RECV, CHECK and FULL; every transition occurs only on a cycle with i_ce high, except the i_clear transition and the i_en abort.
REQ-021 SHALL register last_v (i_v delayed by one i_ce); a start is i_ce && i_v && !last_v.
REQ-022 IDLE: on a start with i_en high, SHALL go to RECV, write i_byte at address 0 (o_wr=1, registered, 1-cycle latency) and set len=1.
REQ-023 A start while i_en is low or the state is FULL SHALL increment o_miss_cnt; the remaining bytes of that packet SHALL be ignored, because only a start leaves IDLE.
REQ-024 RECV, i_ce && i_v: if len < 2^AW, SHALL write at o_waddr=len and increment len; otherwise SHALL set sticky overflow and not write.
REQ-025 i_err sampled high on any i_ce in RECV or CHECK SHALL set the sticky error flag.
REQ-026 RECV, i_ce && !i_v: SHALL go to CHECK, giving upstream checkers one extra byte-time to report.
REQ-027 CHECK, next i_ce: if sticky error, i_err, overflow or len > MAXBYTES, SHALL increment o_drop_cnt and go to IDLE; otherwise SHALL go to FULL, latch o_len=len and set o_pkt_ready.
REQ-028 FULL: i_clear SHALL return the state to IDLE and clear o_pkt_ready on the next clock; i_clear in any other state SHALL be ignored.
REQ-029 i_en falling in RECV or CHECK SHALL abort to IDLE with no count and no o_pkt_ready.
REQ-030 Counters SHALL saturate at 16'hFFFF; i_cnt_clr SHALL take priority over a simultaneous increment.
REQ-031 o_wr SHALL be high for at most one clock per accepted byte and never outside RECV.

Reset
REQ-032 i_reset SHALL asynchronously force state=IDLE, last_v=0, len=0, sticky flags=0, o_wr=0, o_waddr=0, o_wdata=0, o_pkt_ready=0, o_len=0 and both counters=0.

Structure
REQ-033 State encodings and the 16-bit counter width SHALL live in a shared package used by the other enet blocks.
REQ-034 A saturating counter sub-module, satcount16, SHALL be instantiated twice, once per counter.

Verification
REQ-035 64-byte packet, i_en=1, i_err=0 -> 64 writes at addresses 0..63, then o_pkt_ready=1 and o_len=64.
REQ-036 40-byte packet with i_err pulsed in CHECK -> o_drop_cnt=1, o_pkt_ready=0, state IDLE.
REQ-037 Second packet while FULL -> o_miss_cnt=1, no o_wr; after i_clear, a third packet is accepted normally.
REQ-038 With AW=6, a 70-byte packet -> 64 writes, overflow set, o_drop_cnt=1.
REQ-039 i_reset asserted mid-RECV -> all outputs zero immediately; the rest of that packet is ignored until the next start.
REQ-040 Counter preset to 16'hFFFF plus one drop -> stays 16'hFFFF; i_cnt_clr simultaneous with a drop -> counter reads 0.
